// File: rtl/parallel_bus_pollable_memory_if.sv
// Handshake lines of the parallel bus: direction, register select, strobe
// and acknowledge. The tristate data/address byte stays a plain inout pin.
interface parallel_bus_pollable_memory_if;
    logic read;
    logic register_select;
    logic enable;
    logic ack_valid;

    modport master (
        output read,
        output register_select,
        output enable,
        input  ack_valid
    );

    modport slave (
        input  read,
        input  register_select,
        input  enable,
        output ack_valid
    );
endinterface

// File: rtl/parallel_bus_pollable_memory.sv
// Slave end of an asynchronous-handshake 8-bit parallel bus. The master writes
// an address byte, then moves a multi-byte RAM word one byte per strobe, MSB
// first. Byte pointers wrap back to the MSB after the last byte, and a new
// address pulse in the middle of a word is counted as a protocol error.
module parallel_bus_pollable_memory #(
    parameter int WIDTH                         = 8,
    parameter int TRANSACTIONS_PER_WORD         = 2,
    parameter int LOG2_OF_TRANSACTIONS_PER_WORD = $clog2(TRANSACTIONS_PER_WORD)
) (
    input  logic                             clock,
    input  logic                             reset,
    inout  wire  [WIDTH-1:0]                 bus,
    parallel_bus_pollable_memory_if.slave    ctrl,
    output logic [31:0]                      errors,
    output logic [7:0]                       leds
);
    localparam int WORD_WIDTH = TRANSACTIONS_PER_WORD * WIDTH;
    localparam int DEPTH      = 2 ** WIDTH;
    localparam logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] LAST_BYTE =
        LOG2_OF_TRANSACTIONS_PER_WORD'(TRANSACTIONS_PER_WORD - 1);
    localparam logic [3:0] INIT_CLOCKS = 4'd9;

    logic [3:0]                               init_count;
    logic                                     ready;
    logic                                     en;
    logic                                     first;
    logic                                     pre_ack;
    logic [WIDTH-1:0]                         address;
    logic                                     astate;
    logic [1:0]                               wstate;
    logic [1:0]                               rstate;
    logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] wword;
    logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] rword;
    logic [WIDTH-1:0]                         write_data [TRANSACTIONS_PER_WORD];
    logic                                     write_strobe;
    logic [WIDTH-1:0]                         bus_q;
    logic [WORD_WIDTH-1:0]                    write_word;
    logic [WORD_WIDTH-1:0]                    ram_dout;
    logic [WORD_WIDTH-1:0]                    mem [DEPTH];

    // Strobes are ignored until the post-reset stretch has finished.
    assign ready = (init_count == INIT_CLOCKS);
    assign en    = ctrl.enable & ready;
    // pre_ack remembers last clock's enable, so this marks the pulse's first clock.
    assign first = en & ~pre_ack;

    assign bus  = ctrl.read ? bus_q : 'z;
    assign leds = write_data[0][7:0];

    // Post-reset stretch counter: counts up to INIT_CLOCKS and then holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_count <= '0;
        end else if (!ready) begin
            // NOTE: state registers use non-blocking assignments so every
            // always_ff reads the pre-edge values of the others.
            init_count <= init_count + 4'd1;
        end
    end

    // Acknowledge pipeline: enable -> pre_ack -> ack_valid, two clocks each way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_ack        <= 1'b0;
            ctrl.ack_valid <= 1'b0;
        end else begin
            pre_ack        <= en;
            ctrl.ack_valid <= pre_ack;
        end
    end

    // Transaction control: address capture, byte pointers, error count, read byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            address      <= '0;
            astate       <= 1'b0;
            wstate       <= 2'b00;
            rstate       <= 2'b00;
            wword        <= LAST_BYTE;
            rword        <= LAST_BYTE;
            write_strobe <= 1'b0;
            bus_q        <= '0;
            errors       <= '0;
            for (int i = 0; i < TRANSACTIONS_PER_WORD; i++) begin
                write_data[i] <= '0;
            end
        end else begin
            write_strobe <= 1'b0;
            if (en) begin
                if (first) begin
                    if (!ctrl.read && !ctrl.register_select) begin
                        address <= bus;
                        astate  <= 1'b1;
                    end else if (!ctrl.read) begin
                        write_data[wword] <= bus;
                        wstate[0]         <= 1'b1;
                        if (wword == '0) begin
                            wstate[1]    <= 1'b1;
                            write_strobe <= 1'b1;
                        end
                    end else begin
                        rstate[0] <= 1'b1;
                        if (rword == '0) begin
                            rstate[1] <= 1'b1;
                        end
                    end
                end
                if (ctrl.read) begin
                    bus_q <= ram_dout[int'(rword) * WIDTH +: WIDTH];
                end
            end else if (astate) begin
                // A new address abandons any partially transferred word.
                astate <= 1'b0;
                if (wword != LAST_BYTE || rword != LAST_BYTE) begin
                    errors <= errors + 32'd1;
                end
                wstate <= 2'b00;
                rstate <= 2'b00;
                wword  <= LAST_BYTE;
                rword  <= LAST_BYTE;
            end else begin
                if (wstate[1]) begin
                    wstate <= 2'b00;
                    wword  <= LAST_BYTE;
                end else if (wstate[0]) begin
                    wstate[0] <= 1'b0;
                    wword     <= wword - 1'b1;
                end
                if (rstate[1]) begin
                    rstate <= 2'b00;
                    rword  <= LAST_BYTE;
                end else if (rstate[0]) begin
                    rstate[0] <= 1'b0;
                    rword     <= rword - 1'b1;
                end
            end
        end
    end

    // Assemble the RAM write word, byte TRANSACTIONS_PER_WORD-1 in the MSBs.
    always_comb begin
        // NOTE: assigning a default first keeps every bit driven on every
        // path, so no latch is inferred.
        write_word = '0;
        for (int i = 0; i < TRANSACTIONS_PER_WORD; i++) begin
            write_word[i * WIDTH +: WIDTH] = write_data[i];
        end
    end

    // Word RAM: write on the strobe, registered read of the current address.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset branch so it maps onto block RAM;
        // its contents survive reset.
        if (write_strobe) begin
            mem[address] <= write_word;
        end
        ram_dout <= mem[address];
    end
endmodule

// File: tb/tb_parallel_bus_pollable_memory.sv
// Directed bench for parallel_bus_pollable_memory with four bytes per word.
module tb_parallel_bus_pollable_memory;
    localparam int WIDTH = 8;
    localparam int T     = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wire  [WIDTH-1:0] bus;
    logic [WIDTH-1:0] tb_data  = '0;
    logic             tb_drive = 1'b1;
    assign bus = tb_drive ? tb_data : 'z;

    logic [31:0] errors;
    logic [7:0]  leds;

    parallel_bus_pollable_memory_if ctrl ();

    parallel_bus_pollable_memory #(
        .WIDTH                 (WIDTH),
        .TRANSACTIONS_PER_WORD (T)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .ctrl   (ctrl),
        .errors (errors),
        .leds   (leds)
    );

    int strobes = 0;
    always @(negedge clock) if (dut.write_strobe) strobes++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full bus transaction; rise/fall are clocks until ack changes, -1 on timeout.
    task automatic txn(input logic rd, input logic rs, input logic [7:0] data,
                       output logic [7:0] rdata, output int rise, output int fall);
        @(negedge clock);
        ctrl.read            = rd;
        ctrl.register_select = rs;
        tb_data              = data;
        tb_drive             = !rd;
        ctrl.enable          = 1'b1;
        rise = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (ctrl.ack_valid) begin
                rise = i;
                break;
            end
        end
        rdata = bus;
        ctrl.enable = 1'b0;
        fall = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (!ctrl.ack_valid) begin
                fall = i;
                break;
            end
        end
    endtask

    // Transaction whose handshake timing is checked; returns the bus byte.
    task automatic step(input string name, input logic rd, input logic rs,
                        input logic [7:0] data, output logic [7:0] rdata);
        int rise, fall;
        txn(rd, rs, data, rdata, rise, fall);
        check({name, "_ack_rise"}, 32'(rise), 32'd2);
        check({name, "_ack_fall"}, 32'(fall), 32'd2);
    endtask

    typedef struct {
        logic       rd;
        logic       rs;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic rs, input logic [7:0] data,
                       input logic [7:0] exp_rd, input int exp_strobes);
        vec_t e;
        e.rd = rd; e.rs = rs; e.data = data; e.exp_rd = exp_rd; e.exp_strobes = exp_strobes;
        vecs.push_back(e);
    endtask

    task automatic run_table(input int lo, input int hi);
        logic [7:0] rdata;
        for (int i = lo; i <= hi; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rd, vecs[i].rs, vecs[i].data, rdata);
            if (vecs[i].rd)
                check($sformatf("vec%0d_read_data", i), 32'(rdata), 32'(vecs[i].exp_rd));
            else
                check($sformatf("vec%0d_bus_write", i), 32'(rdata), 32'(vecs[i].data));
            check($sformatf("vec%0d_strobes", i), 32'(strobes), 32'(vecs[i].exp_strobes));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdata;
        int         saw_ack;
        int         rise, fall;

        // Vector table: addresses, writes and reads with hand-computed results.
        add(0, 0, 8'h4C, 8'h00, 0);
        add(0, 1, 8'h31, 8'h00, 0);
        add(0, 1, 8'h23, 8'h00, 0);
        add(0, 1, 8'h2A, 8'h00, 0);
        add(0, 1, 8'h12, 8'h00, 1);
        add(1, 1, 8'h00, 8'h31, 1);
        add(1, 1, 8'h00, 8'h23, 1);
        add(1, 1, 8'h00, 8'h2A, 1);
        add(1, 1, 8'h00, 8'h12, 1);
        add(0, 0, 8'h4D, 8'h00, 1);
        add(0, 1, 8'h31, 8'h00, 1);
        add(0, 1, 8'h23, 8'h00, 1);
        add(0, 1, 8'h2B, 8'h00, 1);
        add(0, 1, 8'h34, 8'h00, 2);
        add(0, 0, 8'h4E, 8'h00, 2);
        add(0, 1, 8'h31, 8'h00, 2);
        add(0, 1, 8'h23, 8'h00, 2);
        add(0, 1, 8'h2C, 8'h00, 2);
        add(0, 1, 8'h56, 8'h00, 3);
        add(0, 0, 8'h4F, 8'h00, 3);
        add(0, 1, 8'h31, 8'h00, 3);
        add(0, 1, 8'h23, 8'h00, 3);
        add(0, 1, 8'h2D, 8'h00, 3);
        add(0, 1, 8'h78, 8'h00, 4);
        add(0, 0, 8'h4C, 8'h00, 4);
        add(1, 1, 8'h00, 8'h31, 4);
        add(1, 1, 8'h00, 8'h23, 4);
        add(1, 1, 8'h00, 8'h2A, 4);
        add(1, 1, 8'h00, 8'h12, 4);
        add(0, 0, 8'h4D, 8'h00, 4);
        add(1, 1, 8'h00, 8'h31, 4);
        add(1, 1, 8'h00, 8'h23, 4);
        add(1, 1, 8'h00, 8'h2B, 4);
        add(1, 1, 8'h00, 8'h34, 4);
        add(0, 0, 8'h4E, 8'h00, 4);
        add(1, 1, 8'h00, 8'h31, 4);
        add(1, 1, 8'h00, 8'h23, 4);
        add(1, 1, 8'h00, 8'h2C, 4);
        add(1, 1, 8'h00, 8'h56, 4);
        add(0, 0, 8'h4F, 8'h00, 4);
        add(1, 1, 8'h00, 8'h31, 4);
        add(1, 1, 8'h00, 8'h23, 4);
        add(1, 1, 8'h00, 8'h2D, 4);
        add(1, 1, 8'h00, 8'h78, 4);

        // Reset state.
        ctrl.read            = 1'b0;
        ctrl.register_select = 1'b0;
        ctrl.enable          = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ack", 32'(ctrl.ack_valid), 32'd0);
        check("reset_errors", errors, 32'd0);
        check("reset_leds", 32'(leds), 32'd0);

        // Init stretch: a strobe held through the first 9 clocks is ignored.
        reset                = 1'b1;
        tb_data              = 8'hEE;
        ctrl.enable          = 1'b1;
        saw_ack              = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (ctrl.ack_valid) saw_ack = 1;
        end
        ctrl.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ctrl.ack_valid) saw_ack = 1;
        end
        check("init_no_ack", 32'(saw_ack), 32'd0);

        // Write/read-back of one word, then four addresses.
        run_table(0, 8);
        check("first_word_leds", 32'(leds), 32'h12);
        run_table(9, vecs.size() - 1);
        check("multi_leds", 32'(leds), 32'h78);
        check("multi_errors", errors, 32'd0);

        // Protocol error: new address after two of four data bytes.
        step("perr_addr", 0, 0, 8'h10, rdata);
        step("perr_d0", 0, 1, 8'hA1, rdata);
        step("perr_d1", 0, 1, 8'hA2, rdata);
        step("perr_addr2", 0, 0, 8'h20, rdata);
        check("perr_errors", errors, 32'd1);
        check("perr_no_strobe", 32'(strobes), 32'd4);
        step("perr_w0", 0, 1, 8'hB1, rdata);
        step("perr_w1", 0, 1, 8'hB2, rdata);
        step("perr_w2", 0, 1, 8'hB3, rdata);
        step("perr_w3", 0, 1, 8'hB4, rdata);
        check("perr_strobes", 32'(strobes), 32'd5);
        step("perr_a", 0, 0, 8'h20, rdata);
        step("perr_r0", 1, 1, 8'h00, rdata);
        check("perr_r0_data", 32'(rdata), 32'hB1);
        step("perr_r1", 1, 1, 8'h00, rdata);
        check("perr_r1_data", 32'(rdata), 32'hB2);
        step("perr_r2", 1, 1, 8'h00, rdata);
        check("perr_r2_data", 32'(rdata), 32'hB3);
        step("perr_r3", 1, 1, 8'h00, rdata);
        check("perr_r3_data", 32'(rdata), 32'hB4);
        check("perr_errors_hold", errors, 32'd1);

        // Both pointers mid-word at the next address pulse still count once.
        step("both_addr", 0, 0, 8'h30, rdata);
        step("both_w", 0, 1, 8'hC1, rdata);
        txn(1, 1, 8'h00, rdata, rise, fall);
        step("both_addr0", 0, 0, 8'h00, rdata);
        check("both_errors", errors, 32'd2);

        // Word at address 0, then reset part-way through reading it.
        step("z_w0", 0, 1, 8'h5A, rdata);
        step("z_w1", 0, 1, 8'h6B, rdata);
        step("z_w2", 0, 1, 8'h7C, rdata);
        step("z_w3", 0, 1, 8'h8D, rdata);
        check("z_strobes", 32'(strobes), 32'd6);
        step("z_r0", 1, 1, 8'h00, rdata);
        check("z_r0_data", 32'(rdata), 32'h5A);
        step("z_r1", 1, 1, 8'h00, rdata);
        check("z_r1_data", 32'(rdata), 32'h6B);

        @(negedge clock);
        ctrl.read   = 1'b0;
        tb_drive    = 1'b1;
        reset       = 1'b0;
        repeat (2) @(negedge clock);
        check("midreset_errors", errors, 32'd0);
        check("midreset_leds", 32'(leds), 32'd0);
        check("midreset_ack", 32'(ctrl.ack_valid), 32'd0);
        reset = 1'b1;
        repeat (12) @(negedge clock);

        step("after_r0", 1, 1, 8'h00, rdata);
        check("after_r0_data", 32'(rdata), 32'h5A);
        step("after_r1", 1, 1, 8'h00, rdata);
        check("after_r1_data", 32'(rdata), 32'h6B);
        step("after_r2", 1, 1, 8'h00, rdata);
        check("after_r2_data", 32'(rdata), 32'h7C);
        step("after_r3", 1, 1, 8'h00, rdata);
        check("after_r3_data", 32'(rdata), 32'h8D);
        check("after_errors", errors, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
